// File: rtl/accel_tilt_filter_if.sv
// Sample-side and tilt-side signals between the accelerometer controller and the ball mover.
// Latency: none, wiring only.
// Backpressure: none; the consumer must take every o_valid strobe.
interface accel_tilt_filter_if;
    logic signed [11:0] accel_x;
    logic signed [11:0] accel_y;
    logic               i_data_ready;
    logic               i_calib_req;
    logic signed [7:0]  o_tilt_x;
    logic signed [7:0]  o_tilt_y;
    logic               o_valid;
    logic               o_calibrated;

    // Drives samples and requests, receives tilt.
    modport master (
        output accel_x, accel_y, i_data_ready, i_calib_req,
        input  o_tilt_x, o_tilt_y, o_valid, o_calibrated
    );

    // The filter itself.
    modport slave (
        input  accel_x, accel_y, i_data_ready, i_calib_req,
        output o_tilt_x, o_tilt_y, o_valid, o_calibrated
    );
endinterface

// File: rtl/accel_tilt_filter.sv
// Offset calibration, per-axis first-order IIR and 8-bit tilt output for the accelerometer path.
// Latency: data-ready edge captured at T, offset-corrected at T+1, tilt + o_valid at T+2.
// Backpressure: none; one sample per two cycles at most, never stalls. Optional dead zone: ACCEL_DEADZONE_EN.
module accel_tilt_filter #(
    parameter int CAL_LOG2    = 4,
    parameter int ALPHA_SHIFT = 2,
    parameter int DEADZONE    = 2
) (
    input  logic               CLK,
    input  logic               rst,
    accel_tilt_filter_if.slave bus
);

    localparam int SW = 12 + CAL_LOG2;
    localparam logic [CAL_LOG2-1:0] CNT_ONE = 1;

`ifdef ACCEL_DEADZONE_EN
    localparam bit DZ_ON = 1'b1;
`else
    localparam bit DZ_ON = 1'b0;
`endif

    typedef enum logic {CALIB, RUN} state_t;

    state_t              state;
    logic                dr_q;
    logic                evt_q;
    logic signed [11:0]  ax_q, ay_q;
    logic signed [SW-1:0] sum_x, sum_y;
    logic [CAL_LOG2-1:0] cnt;
    logic signed [11:0]  off_x, off_y;
    logic                s1_vld;
    logic signed [11:0]  d_x, d_y;
    logic signed [15:0]  f_x, f_y;

    logic signed [SW-1:0] sum_x_nxt, sum_y_nxt;
    logic signed [15:0]   f_x_nxt, f_y_nxt;

    // Offset-corrected sample, widened to 13 bits and clamped back into 12.
    function automatic logic signed [11:0] sub_clamp(input logic signed [11:0] a,
                                                     input logic signed [11:0] b);
        logic signed [12:0] d;
        d = {a[11], a} - {b[11], b};
        if (d > 13'sd2047)
            return 12'sh7FF;
        else if (d < -13'sd2048)
            return 12'sh800;
        return d[11:0];
    endfunction

    // One IIR step on the 12.4 state; the 16-bit wrap is exact because the
    // result always lies between the old state and the new target.
    function automatic logic signed [15:0] iir(input logic signed [15:0] f,
                                               input logic signed [11:0] d);
        logic signed [16:0] diff;
        logic signed [15:0] step;
        diff = {d[11], d, 4'b0000} - {f[15], f};
        step = 16'(diff >>> ALPHA_SHIFT);
        return f + step;
    endfunction

    // Small tilts are snapped to zero only on the output; the filter state keeps them.
    function automatic logic signed [7:0] dead_zone(input logic signed [7:0] t);
        int ti;
        ti = int'(t);
        if (DZ_ON && ti > -DEADZONE && ti < DEADZONE)
            return 8'sd0;
        return t;
    endfunction

    assign sum_x_nxt = sum_x + {{CAL_LOG2{ax_q[11]}}, ax_q};
    assign sum_y_nxt = sum_y + {{CAL_LOG2{ay_q[11]}}, ay_q};
    assign f_x_nxt   = iir(f_x, d_x);
    assign f_y_nxt   = iir(f_y, d_y);

    // Edge capture, calibration FSM, two-stage filter pipeline and registered outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state            <= CALIB;
            dr_q             <= 1'b0;
            evt_q            <= 1'b0;
            ax_q             <= '0;
            ay_q             <= '0;
            sum_x            <= '0;
            sum_y            <= '0;
            cnt              <= '0;
            off_x            <= '0;
            off_y            <= '0;
            s1_vld           <= 1'b0;
            d_x              <= '0;
            d_y              <= '0;
            f_x              <= '0;
            f_y              <= '0;
            bus.o_tilt_x     <= '0;
            bus.o_tilt_y     <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_calibrated <= 1'b0;
        end else begin
            dr_q        <= bus.i_data_ready;
            // A recalibration request in the edge cycle swallows that sample.
            evt_q       <= bus.i_data_ready & ~dr_q & ~bus.i_calib_req;
            bus.o_valid <= 1'b0;
            if (bus.i_data_ready && !dr_q) begin
                ax_q <= bus.accel_x;
                ay_q <= bus.accel_y;
            end

            if (bus.i_calib_req) begin
                state            <= CALIB;
                sum_x            <= '0;
                sum_y            <= '0;
                cnt              <= '0;
                f_x              <= '0;
                f_y              <= '0;
                s1_vld           <= 1'b0;
                bus.o_tilt_x     <= '0;
                bus.o_tilt_y     <= '0;
                bus.o_calibrated <= 1'b0;
            end else begin
                s1_vld <= 1'b0;
                case (state)
                    CALIB: begin
                        if (evt_q) begin
                            if (cnt == '1) begin
                                off_x            <= 12'(sum_x_nxt >>> CAL_LOG2);
                                off_y            <= 12'(sum_y_nxt >>> CAL_LOG2);
                                sum_x            <= '0;
                                sum_y            <= '0;
                                cnt              <= '0;
                                f_x              <= '0;
                                f_y              <= '0;
                                state            <= RUN;
                                bus.o_calibrated <= 1'b1;
                            end else begin
                                sum_x <= sum_x_nxt;
                                sum_y <= sum_y_nxt;
                                cnt   <= cnt + CNT_ONE;
                            end
                        end
                    end
                    RUN: begin
                        if (evt_q) begin
                            d_x    <= sub_clamp(ax_q, off_x);
                            d_y    <= sub_clamp(ay_q, off_y);
                            s1_vld <= 1'b1;
                        end
                        if (s1_vld) begin
                            f_x          <= f_x_nxt;
                            f_y          <= f_y_nxt;
                            bus.o_tilt_x <= dead_zone(f_x_nxt[15:8]);
                            bus.o_tilt_y <= dead_zone(f_y_nxt[15:8]);
                            bus.o_valid  <= 1'b1;
                        end
                    end
                    default: state <= CALIB;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Self-checking bench: two filters (alpha shift 2 and 0) fed the same samples, checked against an arithmetic model.
// Latency: each sample is observed over four cycles (idle, T, T+1, T+2).
// Backpressure: none; requests can be injected at the edge, one cycle later, or while stage 1 is in flight.
module tb_accel_tilt_filter;

    localparam int CAL_N = 16;
    localparam int DZ    = 2;
`ifdef ACCEL_DEADZONE_EN
    localparam bit DZ_ON = 1'b1;
`else
    localparam bit DZ_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    accel_tilt_filter_if if_a ();
    accel_tilt_filter_if if_p ();

    accel_tilt_filter #(.CAL_LOG2(4), .ALPHA_SHIFT(2), .DEADZONE(DZ)) dut_a (
        .CLK(CLK), .rst(rst), .bus(if_a.slave));
    accel_tilt_filter #(.CAL_LOG2(4), .ALPHA_SHIFT(0), .DEADZONE(DZ)) dut_p (
        .CLK(CLK), .rst(rst), .bus(if_p.slave));

    int chk = 0;
    int err = 0;

    // Reference model: calibration mean, clamp, IIR on a 12.4 fixed-point integer.
    int sh [2] = '{2, 0};
    bit m_run;
    int m_cnt, m_sx, m_sy, m_ox, m_oy;
    int m_fx [2];
    int m_fy [2];
    int m_tx [2];
    int m_ty [2];

    // Observations per DUT: valid at {idle, T, T+1, T+2}, calibrated at T+1/T+2, tilt at T+2.
    logic [3:0] ob_v  [2];
    logic [7:0] ob_tx [2];
    logic [7:0] ob_ty [2];
    logic       ob_c1 [2];
    logic       ob_c2 [2];

    function automatic int clamp12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int dz(input int t);
        if (DZ_ON && t > -DZ && t < DZ) return 0;
        return t;
    endfunction

    task automatic model_clear();
        m_run = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
        for (int k = 0; k < 2; k++) begin
            m_fx[k] = 0; m_fy[k] = 0; m_tx[k] = 0; m_ty[k] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_ox = 0; m_oy = 0;
    endtask

    // phase: 0 none, 1 request with the edge, 2 one cycle later, 3 while stage 1 is in flight.
    task automatic model_sample(input int x, input int y, input int phase,
                                output bit ev, output bit c1, output bit c2);
        int dx, dy;
        ev = 0;
        if (phase == 1 || phase == 2) begin
            model_clear();
            c1 = 0; c2 = 0;
            return;
        end
        if (!m_run) begin
            m_sx += x; m_sy += y; m_cnt++;
            if (m_cnt == CAL_N) begin
                m_ox = m_sx >>> 4; m_oy = m_sy >>> 4;
                m_sx = 0; m_sy = 0; m_cnt = 0; m_run = 1;
                for (int k = 0; k < 2; k++) begin m_fx[k] = 0; m_fy[k] = 0; end
            end
        end else begin
            dx = clamp12(x - m_ox);
            dy = clamp12(y - m_oy);
            for (int k = 0; k < 2; k++) begin
                m_fx[k] = m_fx[k] + ((dx * 16 - m_fx[k]) >>> sh[k]);
                m_fy[k] = m_fy[k] + ((dy * 16 - m_fy[k]) >>> sh[k]);
                m_tx[k] = dz(m_fx[k] >>> 8);
                m_ty[k] = dz(m_fy[k] >>> 8);
            end
            ev = 1;
        end
        c1 = m_run; c2 = m_run;
        if (phase == 3) begin
            model_clear();
            ev = 0; c2 = 0;
        end
    endtask

    task automatic set_in(input int x, input int y, input logic dr, input logic req);
        if_a.accel_x = 12'(x); if_p.accel_x = 12'(x);
        if_a.accel_y = 12'(y); if_p.accel_y = 12'(y);
        if_a.i_data_ready = dr; if_p.i_data_ready = dr;
        if_a.i_calib_req = req; if_p.i_calib_req = req;
    endtask

    task automatic drive(input int x, input int y, input int phase);
        @(negedge CLK);
        ob_v[0][3] = if_a.o_valid; ob_v[1][3] = if_p.o_valid;
        set_in(x, y, 1'b1, phase == 1);
        @(negedge CLK);
        ob_v[0][2] = if_a.o_valid; ob_v[1][2] = if_p.o_valid;
        set_in(x, y, 1'b1, phase == 2);
        @(negedge CLK);
        ob_v[0][1] = if_a.o_valid; ob_v[1][1] = if_p.o_valid;
        ob_c1[0] = if_a.o_calibrated; ob_c1[1] = if_p.o_calibrated;
        set_in(x, y, 1'b1, phase == 3);
        @(negedge CLK);
        ob_v[0][0] = if_a.o_valid; ob_v[1][0] = if_p.o_valid;
        ob_c2[0] = if_a.o_calibrated; ob_c2[1] = if_p.o_calibrated;
        ob_tx[0] = if_a.o_tilt_x; ob_tx[1] = if_p.o_tilt_x;
        ob_ty[0] = if_a.o_tilt_y; ob_ty[1] = if_p.o_tilt_y;
        set_in(x, y, 1'b0, 1'b0);
    endtask

    task automatic pulse_calib();
        @(negedge CLK); set_in(0, 0, 1'b0, 1'b1);
        @(negedge CLK); set_in(0, 0, 1'b0, 1'b0);
        model_clear();
    endtask

    task automatic do_reset();
        @(negedge CLK); rst = 1'b1;
        @(negedge CLK); rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_in(0, 0, 1'b0, 1'b0);
        do_reset();
        @(negedge CLK);
        chk++; if (if_a.o_valid !== 1'b0 || if_p.o_valid !== 1'b0) begin err++;
            $display("FAIL reset_valid got %b%b exp 00", if_a.o_valid, if_p.o_valid); end
        chk++; if (if_a.o_calibrated !== 1'b0 || if_p.o_calibrated !== 1'b0) begin err++;
            $display("FAIL reset_calibrated got %b%b exp 00", if_a.o_calibrated, if_p.o_calibrated); end
        chk++; if (if_a.o_tilt_x !== 8'd0 || if_a.o_tilt_y !== 8'd0) begin err++;
            $display("FAIL reset_tilt_a got %0d/%0d exp 0/0", if_a.o_tilt_x, if_a.o_tilt_y); end
        chk++; if (if_p.o_tilt_x !== 8'd0 || if_p.o_tilt_y !== 8'd0) begin err++;
            $display("FAIL reset_tilt_p got %0d/%0d exp 0/0", if_p.o_tilt_x, if_p.o_tilt_y); end
    endtask

    task automatic test_calibration();
        bit ev, c1, c2;
        for (int i = 0; i < CAL_N + 1; i++) begin
            drive(64, -64, 0);
            model_sample(64, -64, 0, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL cal_valid s%0d dut%0d got %b exp %b", i, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_c1[k] !== c1 || ob_c2[k] !== c2) begin err++;
                    $display("FAIL cal_calibrated s%0d dut%0d got %b%b exp %b%b", i, k, ob_c1[k], ob_c2[k], c1, c2); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL cal_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
        end
        chk++; if (ob_tx[0] !== 8'd0 || ob_ty[0] !== 8'd0 || ob_v[0] !== 4'b0001) begin err++;
            $display("FAIL cal_zero_after got v=%b %0d/%0d exp v=0001 0/0", ob_v[0], $signed(ob_tx[0]), $signed(ob_ty[0])); end
    endtask

    task automatic test_step();
        bit ev, c1, c2;
        int x;
        int ex_a [2] = '{16, 28};
        pulse_calib();
        for (int i = 0; i < CAL_N + 2; i++) begin
            x = (i < CAL_N) ? 0 : 1024;
            drive(x, 0, 0);
            model_sample(x, 0, 0, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL step_valid s%0d dut%0d got %b exp %b", i, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL step_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
            if (i >= CAL_N) begin
                chk++; if (ob_tx[0] !== 8'(ex_a[i-CAL_N])) begin err++;
                    $display("FAIL step_const s%0d got %0d exp %0d", i, $signed(ob_tx[0]), ex_a[i-CAL_N]); end
            end
        end
    endtask

    task automatic test_saturation();
        bit ev, c1, c2;
        int cx, sx, ex;
        for (int r = 0; r < 2; r++) begin
            cx = (r == 0) ? -2000 : 2000;
            sx = (r == 0) ? 2047 : -2048;
            ex = (r == 0) ? 127 : -128;
            pulse_calib();
            for (int i = 0; i < CAL_N + 1; i++) begin
                if (i < CAL_N) begin
                    drive(cx, -cx, 0); model_sample(cx, -cx, 0, ev, c1, c2);
                end else begin
                    drive(sx, -1 - sx, 0); model_sample(sx, -1 - sx, 0, ev, c1, c2);
                end
                for (int k = 0; k < 2; k++) begin
                    chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                        $display("FAIL sat_valid r%0d s%0d dut%0d got %b exp %b", r, i, k, ob_v[k], {3'b000, ev}); end
                    chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                        $display("FAIL sat_tilt r%0d s%0d dut%0d got %0d/%0d exp %0d/%0d", r, i, k,
                                 $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
                end
            end
            chk++; if (ob_tx[1] !== 8'(ex) || ob_ty[1] !== 8'(-1 - ex)) begin err++;
                $display("FAIL sat_const r%0d got %0d/%0d exp %0d/%0d", r, $signed(ob_tx[1]), $signed(ob_ty[1]), ex, -1 - ex); end
        end
    endtask

    task automatic test_deadzone();
        bit ev, c1, c2;
        int xs [3] = '{16, 32, -16};
        int ex_on [3] = '{0, 2, 0};
        int ex_off [3] = '{1, 2, -1};
        int x, ex;
        pulse_calib();
        for (int i = 0; i < CAL_N + 3; i++) begin
            x = (i < CAL_N) ? 0 : xs[i-CAL_N];
            drive(x, -x, 0);
            model_sample(x, -x, 0, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL dz_valid s%0d dut%0d got %b exp %b", i, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL dz_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
            if (i >= CAL_N) begin
                ex = DZ_ON ? ex_on[i-CAL_N] : ex_off[i-CAL_N];
                chk++; if (ob_tx[1] !== 8'(ex)) begin err++;
                    $display("FAIL dz_const s%0d got %0d exp %0d", i, $signed(ob_tx[1]), ex); end
            end
        end
    endtask

    task automatic test_collision();
        bit ev, c1, c2;
        int ph, x, y;
        for (int i = 0; i < 54; i++) begin
            ph = (i == 0) ? 1 : (i == 18) ? 2 : (i == 35) ? 3 : 0;
            x = int'($urandom_range(0, 1023)) - 512;
            y = int'($urandom_range(0, 1023)) - 512;
            drive(x, y, ph);
            model_sample(x, y, ph, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL coll_valid s%0d ph%0d dut%0d got %b exp %b", i, ph, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_c1[k] !== c1 || ob_c2[k] !== c2) begin err++;
                    $display("FAIL coll_calibrated s%0d dut%0d got %b%b exp %b%b", i, k, ob_c1[k], ob_c2[k], c1, c2); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL coll_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
            if (ph == 1) begin
                chk++; if (ob_c1[0] !== 1'b0 || ob_v[0] !== 4'b0000 || ob_tx[0] !== 8'd0) begin err++;
                    $display("FAIL coll_edge_const got c=%b v=%b t=%0d exp c=0 v=0000 t=0", ob_c1[0], ob_v[0], $signed(ob_tx[0])); end
            end
        end
    endtask

    task automatic test_reset_mid_cal();
        bit ev, c1, c2;
        pulse_calib();
        for (int i = 0; i < 10; i++) begin
            drive(-1500, 900, 0); model_sample(-1500, 900, 0, ev, c1, c2);
        end
        do_reset();
        for (int i = 0; i < CAL_N + 1; i++) begin
            drive(100, -100, 0);
            model_sample(100, -100, 0, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL rstcal_valid s%0d dut%0d got %b exp %b", i, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_c1[k] !== c1 || ob_c2[k] !== c2) begin err++;
                    $display("FAIL rstcal_calibrated s%0d dut%0d got %b%b exp %b%b", i, k, ob_c1[k], ob_c2[k], c1, c2); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL rstcal_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
        end
        chk++; if (ob_tx[0] !== 8'd0 || ob_ty[0] !== 8'd0 || ob_tx[1] !== 8'd0 || ob_ty[1] !== 8'd0) begin err++;
            $display("FAIL rstcal_offset got %0d/%0d %0d/%0d exp all 0", $signed(ob_tx[0]), $signed(ob_ty[0]),
                     $signed(ob_tx[1]), $signed(ob_ty[1])); end
    endtask

    task automatic test_random();
        bit ev, c1, c2;
        int ph, x, y;
        for (int i = 0; i < 200; i++) begin
            ph = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 3)) : 0;
            x = int'($urandom_range(0, 4095)) - 2048;
            y = int'($urandom_range(0, 4095)) - 2048;
            drive(x, y, ph);
            model_sample(x, y, ph, ev, c1, c2);
            for (int k = 0; k < 2; k++) begin
                chk++; if (ob_v[k] !== {3'b000, ev}) begin err++;
                    $display("FAIL rand_valid s%0d ph%0d dut%0d got %b exp %b", i, ph, k, ob_v[k], {3'b000, ev}); end
                chk++; if (ob_c1[k] !== c1 || ob_c2[k] !== c2) begin err++;
                    $display("FAIL rand_calibrated s%0d dut%0d got %b%b exp %b%b", i, k, ob_c1[k], ob_c2[k], c1, c2); end
                chk++; if (ob_tx[k] !== 8'(m_tx[k]) || ob_ty[k] !== 8'(m_ty[k])) begin err++;
                    $display("FAIL rand_tilt s%0d dut%0d got %0d/%0d exp %0d/%0d", i, k,
                             $signed(ob_tx[k]), $signed(ob_ty[k]), m_tx[k], m_ty[k]); end
            end
        end
    endtask

    initial begin
        set_in(0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        test_reset();
        test_calibration();
        test_step();
        test_saturation();
        test_deadzone();
        test_collision();
        test_reset_mid_cal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
